// File: rtl/frame_scanner_pkg.sv
// Shared types and constants for the frame_scanner pixel source.
package frame_scanner_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    HBLANK = 2'd2,
    VBLANK = 2'd3
  } state_t;

  localparam int COORD_W = 11;
  localparam logic [COORD_W-1:0] COORD_INVALID = 11'h7FF;
  localparam int BLK_W = 16;

  function automatic logic in_left_half(input logic [COORD_W-1:0] x, input int h_active);
    return (int'(x) < (h_active / 2));
  endfunction

endpackage

// File: rtl/frame_scanner_scan_counter.sv
// Column/row/address/blanking counters with terminal-count flags for frame_scanner.
module scan_counter
  import frame_scanner_pkg::*;
#(
  parameter int H_ACTIVE = 200,
  parameter int V_ACTIVE = 164,
  parameter int H_BLANK  = 8,
  parameter int V_BLANK  = 4,
  parameter int ADDR_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               frame_clr,
  input  logic               col_en,
  input  logic               row_inc,
  input  logic               blk_en,
  output logic [COORD_W-1:0] col,
  output logic [COORD_W-1:0] row,
  output logic [ADDR_W-1:0]  addr,
  output logic [BLK_W-1:0]   blk,
  output logic               col_last,
  output logic               row_last,
  output logic               hblank_last,
  output logic               vblank_last
);

  logic [COORD_W-1:0] col_r;
  logic [COORD_W-1:0] row_r;
  logic [ADDR_W-1:0]  addr_r;
  logic [BLK_W-1:0]   blk_r;

  // Raster position and linear RAM address; address only ever increments, no multiply.
  always_ff @(posedge clk) begin
    if (!rst) begin
      col_r  <= {COORD_W{1'b0}};
      row_r  <= {COORD_W{1'b0}};
      addr_r <= {ADDR_W{1'b0}};
    end else if (frame_clr) begin
      col_r  <= {COORD_W{1'b0}};
      row_r  <= {COORD_W{1'b0}};
      addr_r <= {ADDR_W{1'b0}};
    end else begin
      if (col_en) begin
        addr_r <= addr_r + ADDR_W'(1'b1);
        col_r  <= col_last ? {COORD_W{1'b0}} : col_r + COORD_W'(1'b1);
      end
      if (row_inc) begin
        row_r <= row_r + COORD_W'(1'b1);
      end
    end
  end

  // Blanking cycle counter; restarts whenever the FSM stops enabling it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      blk_r <= {BLK_W{1'b0}};
    end else if (blk_en) begin
      blk_r <= blk_r + BLK_W'(1'b1);
    end else begin
      blk_r <= {BLK_W{1'b0}};
    end
  end

  assign col         = col_r;
  assign row         = row_r;
  assign addr        = addr_r;
  assign blk         = blk_r;
  assign col_last    = (col_r == COORD_W'(H_ACTIVE - 1));
  assign row_last    = (row_r == COORD_W'(V_ACTIVE - 1));
  assign hblank_last = (blk_r == BLK_W'(H_BLANK - 1));
  assign vblank_last = (blk_r == BLK_W'(V_BLANK - 1));

endmodule

// File: rtl/frame_scanner.sv
// Raster-scans a stored frame from synchronous RAM as x/y/data beats with blanking.
// Build option: FRAME_SCANNER_TEST_PATTERN_EN replaces RAM data with a half-black/half-white pattern.
module frame_scanner
  import frame_scanner_pkg::*;
#(
  parameter int H_ACTIVE = 200,
  parameter int V_ACTIVE = 164,
  parameter int H_BLANK  = 8,
  parameter int V_BLANK  = 4,
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               frame_req,
  output logic               mem_rd,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic [DATA_W-1:0]  mem_data,
  output logic               pix_valid,
  output logic [COORD_W-1:0] x_pos,
  output logic [COORD_W-1:0] y_pos,
  output logic [DATA_W-1:0]  data_out,
  output logic               frame_start,
  output logic               frame_done,
  output logic               busy
);

  state_t state_r, state_next_s;
  logic frame_clr_s, col_en_s, row_inc_s, blk_en_s;
  logic [COORD_W-1:0] col_s, row_s;
  logic [ADDR_W-1:0]  addr_s;
  logic [BLK_W-1:0]   blk_s, blk_next_s;
  logic col_last_s, row_last_s, hb_last_s, vb_last_s, done_next_s;

  logic mem_rd_r, busy_r, frame_done_r;
  logic v1_r, fs1_r;
  logic [COORD_W-1:0] x1_r, y1_r;
  logic pix_valid_r, frame_start_r;
  logic [COORD_W-1:0] x_pos_r, y_pos_r;
  logic [DATA_W-1:0]  data_out_r, pix_data_s;

  scan_counter #(
    .H_ACTIVE(H_ACTIVE), .V_ACTIVE(V_ACTIVE), .H_BLANK(H_BLANK),
    .V_BLANK(V_BLANK), .ADDR_W(ADDR_W)
  ) u_cnt (
    .clk(clk), .rst(rst), .frame_clr(frame_clr_s), .col_en(col_en_s),
    .row_inc(row_inc_s), .blk_en(blk_en_s), .col(col_s), .row(row_s),
    .addr(addr_s), .blk(blk_s), .col_last(col_last_s), .row_last(row_last_s),
    .hblank_last(hb_last_s), .vblank_last(vb_last_s)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state and counter control; frame_req only matters in IDLE and the last VBLANK cycle.
  always_comb begin
    state_next_s = state_r;
    frame_clr_s  = 1'b0;
    col_en_s     = 1'b0;
    row_inc_s    = 1'b0;
    blk_en_s     = 1'b0;
    case (state_r)
      IDLE: begin
        if (frame_req) begin
          state_next_s = ACTIVE;
          frame_clr_s  = 1'b1;
        end else begin
          state_next_s = IDLE;
        end
      end
      ACTIVE: begin
        col_en_s = 1'b1;
        if (col_last_s) begin
          state_next_s = HBLANK;
        end else begin
          state_next_s = ACTIVE;
        end
      end
      HBLANK: begin
        if (hb_last_s) begin
          row_inc_s    = 1'b1;
          state_next_s = row_last_s ? VBLANK : ACTIVE;
        end else begin
          blk_en_s = 1'b1;
        end
      end
      VBLANK: begin
        if (vb_last_s) begin
          if (frame_req) begin
            state_next_s = ACTIVE;
            frame_clr_s  = 1'b1;
          end else begin
            state_next_s = IDLE;
          end
        end else begin
          blk_en_s = 1'b1;
        end
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // Look ahead one cycle so frame_done can be a register landing on the final VBLANK cycle.
  always_comb begin
    blk_next_s  = blk_en_s ? (blk_s + BLK_W'(1'b1)) : {BLK_W{1'b0}};
    done_next_s = (state_next_s == VBLANK) && (blk_next_s == BLK_W'(V_BLANK - 1));
  end

  // Registered control outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      mem_rd_r     <= 1'b0;
      busy_r       <= 1'b0;
      frame_done_r <= 1'b0;
    end else begin
      mem_rd_r     <= (state_next_s == ACTIVE);
      busy_r       <= (state_next_s != IDLE);
      frame_done_r <= done_next_s;
    end
  end

  // Pixel value source.
  always_comb begin
`ifdef FRAME_SCANNER_TEST_PATTERN_EN
    pix_data_s = in_left_half(x1_r, H_ACTIVE) ? {DATA_W{1'b0}} : {DATA_W{1'b1}};
`else
    pix_data_s = mem_data;
`endif
  end

  // Two-stage output pipeline matching the RAM read latency.
  always_ff @(posedge clk) begin
    if (!rst) begin
      v1_r          <= 1'b0;
      fs1_r         <= 1'b0;
      x1_r          <= {COORD_W{1'b0}};
      y1_r          <= {COORD_W{1'b0}};
      pix_valid_r   <= 1'b0;
      frame_start_r <= 1'b0;
      x_pos_r       <= COORD_INVALID;
      y_pos_r       <= COORD_INVALID;
      data_out_r    <= {DATA_W{1'b0}};
    end else begin
      v1_r          <= (state_r == ACTIVE);
      fs1_r         <= (state_r == ACTIVE) && (col_s == {COORD_W{1'b0}}) && (row_s == {COORD_W{1'b0}});
      x1_r          <= col_s;
      y1_r          <= row_s;
      pix_valid_r   <= v1_r;
      frame_start_r <= fs1_r;
      x_pos_r       <= v1_r ? x1_r : COORD_INVALID;
      y_pos_r       <= v1_r ? y1_r : COORD_INVALID;
      data_out_r    <= v1_r ? pix_data_s : {DATA_W{1'b0}};
    end
  end

  assign mem_rd      = mem_rd_r;
  assign mem_addr    = addr_s;
  assign busy        = busy_r;
  assign frame_done  = frame_done_r;
  assign pix_valid   = pix_valid_r;
  assign frame_start = frame_start_r;
  assign x_pos       = x_pos_r;
  assign y_pos       = y_pos_r;
  assign data_out    = data_out_r;

endmodule

// File: tb/tb_frame_scanner.sv
// Directed self-checking bench for frame_scanner with a synchronous RAM model holding addr[7:0].
module tb_frame_scanner;

  logic        clk = 1'b0;
  logic        rst;
  logic        frame_req;
  logic        mem_rd;
  logic [15:0] mem_addr;
  logic [7:0]  mem_data = 8'h00;
  logic        pix_valid;
  logic [10:0] x_pos, y_pos;
  logic [7:0]  data_out;
  logic        frame_start, frame_done, busy;

  int total = 0;
  int bad   = 0;

`ifdef FRAME_SCANNER_TEST_PATTERN_EN
  localparam logic [7:0] EXP_L1_DATA   = 8'h00;
  localparam logic [7:0] EXP_LAST_DATA = 8'hFF;
  localparam logic [7:0] EXP_MID_DATA  = 8'h00;
  localparam int         EXP_ZEROS     = 16400;
`else
  localparam logic [7:0] EXP_L1_DATA   = 8'hC8;
  localparam logic [7:0] EXP_LAST_DATA = 8'h1F;
  localparam logic [7:0] EXP_MID_DATA  = 8'hD2;
  localparam int         EXP_ZEROS     = 129;
`endif

  frame_scanner dut (
    .clk(clk), .rst(rst), .frame_req(frame_req), .mem_rd(mem_rd),
    .mem_addr(mem_addr), .mem_data(mem_data), .pix_valid(pix_valid),
    .x_pos(x_pos), .y_pos(y_pos), .data_out(data_out),
    .frame_start(frame_start), .frame_done(frame_done), .busy(busy)
  );

  always #5 clk = ~clk;

  // RAM contents are addr[7:0]; data valid the cycle after the read strobe.
  always @(posedge clk) begin
    if (mem_rd) mem_data <= mem_addr[7:0];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  int first_n, first_x, first_y, first_d, first_fs;
  int beats, zeros, fs_cnt, fd_cnt, fd_n, gap_bad, seen_last, last_d;
  int l1_x, l1_y, l1_v, l1_d, busy_after, rd_after;
  int b2b_fd, b2b_rd, b2b_addr, b2b_busy, b2b_v, b2b_x, b2b_y, b2b_fs;
  int found, mid_d, post_fd;

  initial begin
    rst = 1'b0;
    frame_req = 1'b0;
    repeat (3) tick();
    chk("rst_valid", pix_valid, 1'b0);
    chk("rst_x", x_pos, 11'h7FF);
    chk("rst_y", y_pos, 11'h7FF);
    chk("rst_busy", busy, 1'b0);
    chk("rst_memrd", mem_rd, 1'b0);
    chk("rst_data", data_out, 8'h00);
    rst = 1'b1;
    repeat (2) tick();

    // Frame 1: single-cycle request, full monitor.
    first_n = -1; beats = 0; zeros = 0; fs_cnt = 0; fd_cnt = 0; fd_n = -1;
    gap_bad = 0; seen_last = 0; last_d = -1; busy_after = -1; rd_after = -1;
    l1_x = -1; l1_y = -1; l1_v = -1; l1_d = -1;
    first_x = -1; first_y = -1; first_d = -1; first_fs = -1;
    frame_req = 1'b1;
    tick();
    frame_req = 1'b0;
    chk("t1_memrd", mem_rd, 1'b1);
    chk("t1_addr", mem_addr, 16'd0);
    chk("t1_busy", busy, 1'b1);
    for (int n = 2; n <= 34130; n++) begin
      tick();
      if (pix_valid) begin
        beats++;
        if (data_out == 8'h00) zeros++;
        if (frame_start) fs_cnt++;
        if (first_n < 0) begin
          first_n = n; first_x = x_pos; first_y = y_pos; first_d = data_out; first_fs = frame_start;
        end
        if (x_pos == 11'd199 && y_pos == 11'd163) begin
          seen_last = 1; last_d = data_out;
        end
      end
      if (n >= 203 && n <= 210 && (pix_valid || x_pos != 11'h7FF || y_pos != 11'h7FF || data_out != 8'h00))
        gap_bad = 1;
      if (n == 211) begin
        l1_x = x_pos; l1_y = y_pos; l1_v = pix_valid; l1_d = data_out;
      end
      if (frame_done) begin
        fd_cnt++; fd_n = n;
      end
      if (n == 34117) begin
        busy_after = busy; rd_after = mem_rd;
      end
    end
    chk("first_latency", first_n, 3);
    chk("first_x", first_x, 0);
    chk("first_y", first_y, 0);
    chk("first_data", first_d, 0);
    chk("first_fstart", first_fs, 1);
    chk("fstart_count", fs_cnt, 1);
    chk("beat_count", beats, 32800);
    chk("zero_count", zeros, EXP_ZEROS);
    chk("last_seen", seen_last, 1);
    chk("last_data", last_d, EXP_LAST_DATA);
    chk("hblank_gap", gap_bad, 0);
    chk("line1_x", l1_x, 0);
    chk("line1_y", l1_y, 1);
    chk("line1_valid", l1_v, 1);
    chk("line1_data", l1_d, EXP_L1_DATA);
    chk("fdone_count", fd_cnt, 1);
    chk("fdone_cycle", fd_n, 34116);
    chk("idle_busy", busy_after, 0);
    chk("idle_memrd", rd_after, 0);

    // Back-to-back: request held through the end of the first frame.
    b2b_fd = 0; b2b_rd = -1; b2b_addr = -1; b2b_busy = -1; b2b_v = -1; b2b_x = -1; b2b_y = -1; b2b_fs = -1;
    frame_req = 1'b1;
    for (int n = 1; n <= 34119; n++) begin
      tick();
      if (n == 34116) b2b_fd = frame_done;
      if (n == 34117) begin
        b2b_rd = mem_rd; b2b_addr = mem_addr; b2b_busy = busy;
        frame_req = 1'b0;
      end
      if (n == 34119) begin
        b2b_v = pix_valid; b2b_x = x_pos; b2b_y = y_pos; b2b_fs = frame_start;
      end
    end
    chk("b2b_fdone", b2b_fd, 1);
    chk("b2b_memrd", b2b_rd, 1);
    chk("b2b_addr", b2b_addr, 0);
    chk("b2b_busy", b2b_busy, 1);
    chk("b2b_valid", b2b_v, 1);
    chk("b2b_x", b2b_x, 0);
    chk("b2b_y", b2b_y, 0);
    chk("b2b_fstart", b2b_fs, 1);

    // Mid-frame reset at pixel (50,20).
    found = 0; mid_d = -1;
    for (int n = 0; n < 6000; n++) begin
      if (pix_valid && x_pos == 11'd50 && y_pos == 11'd20) begin
        found = 1; mid_d = data_out;
        break;
      end
      tick();
    end
    chk("mid_found", found, 1);
    chk("mid_data", mid_d, EXP_MID_DATA);
    rst = 1'b0;
    tick();
    chk("abort_valid", pix_valid, 1'b0);
    chk("abort_x", x_pos, 11'h7FF);
    chk("abort_y", y_pos, 11'h7FF);
    chk("abort_busy", busy, 1'b0);
    chk("abort_memrd", mem_rd, 1'b0);
    chk("abort_fdone", frame_done, 1'b0);
    rst = 1'b1;
    post_fd = 0;
    for (int n = 0; n < 40; n++) begin
      tick();
      if (frame_done || busy) post_fd++;
    end
    chk("abort_quiet", post_fd, 0);
    frame_req = 1'b1;
    tick();
    frame_req = 1'b0;
    chk("restart_memrd", mem_rd, 1'b1);
    chk("restart_addr", mem_addr, 16'd0);
    repeat (2) tick();
    chk("restart_valid", pix_valid, 1'b1);
    chk("restart_x", x_pos, 11'd0);
    chk("restart_y", y_pos, 11'd0);
    chk("restart_fstart", frame_start, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/frame_scanner.md
# frame_scanner

Pixel-stream source for the camera/game datapath: reads a stored grayscale frame from a synchronous frame RAM and raster-scans it out as `x_pos`/`y_pos`/`data_out` beats. This is the stream that the left/right dark-pixel counting logic consumes. Blanking gaps are inserted between lines and between frames. Coordinates are forced to an out-of-window sentinel while no pixel is valid.

## Interface
Parameters:
- `H_ACTIVE`, 200: pixels per line.
- `V_ACTIVE`, 164: lines per frame.
- `H_BLANK`, 8: idle cycles after every line, including the last line.
- `V_BLANK`, 4: idle cycles after the last line's H_BLANK.
- `ADDR_W`, 16: frame RAM address width. Must satisfy 2^ADDR_W ≥ H_ACTIVE·V_ACTIVE.
- `DATA_W`, 8: pixel width.

Ports:
- `clk`  in  1: single clock.
- `rst`  in  1: synchronous, active-low reset.
- `frame_req`  in  1: level. Requests a frame scan.
- `mem_rd`  out  1: RAM read strobe.
- `mem_addr`  out  ADDR_W: RAM read address.
- `mem_data`  in  DATA_W: RAM read data, valid the cycle after `mem_rd`.
- `pix_valid`  out  1: high when `x_pos`/`y_pos`/`data_out` carry a pixel.
- `x_pos`  out  11: column.
- `y_pos`  out  11: row.
- `data_out`  out  DATA_W: pixel value.
- `frame_start`  out  1: one-cycle pulse, coincident with pixel (0,0).
- `frame_done`  out  1: one-cycle pulse in the final V_BLANK cycle.
- `busy`  out  1: high in every state other than IDLE.

## Operation
- FSM states: IDLE, ACTIVE, HBLANK, VBLANK.
- IDLE → ACTIVE when `frame_req` = 1 is sampled.
- ACTIVE: issues one read per cycle (`mem_rd` = 1). Column counter runs 0..H_ACTIVE-1, then → HBLANK.
- HBLANK: lasts H_BLANK cycles. Row counter increments.
  - If the row was V_ACTIVE-1 → VBLANK.
  - Otherwise → ACTIVE.
- VBLANK: lasts V_BLANK cycles. In the last cycle, `frame_done` = 1.
  - If `frame_req` = 1 in that cycle → ACTIVE, so back-to-back frames have no IDLE gap.
  - Otherwise → IDLE.
- `frame_req` is ignored outside IDLE and the last VBLANK cycle.
- `mem_addr` is an incrementing counter: +1 per ACTIVE cycle, held during blanking, cleared to 0 on entry to each frame. No multiplier is used.
- The output stage delays column, row and `frame_start` by two cycles to align with the registered `mem_data`.
- While `pix_valid` = 0:
  - `x_pos` = `y_pos` = 11'h7FF (sentinel that falls outside every counting window).
  - `data_out` = 0.
- Reset values: all outputs 0, except `x_pos`/`y_pos` = 11'h7FF. State = IDLE, counters = 0.
- Reset mid-frame aborts the scan. No `frame_done` is emitted. The next frame restarts at (0,0).

## Timing
- Edge T0 samples `frame_req` in IDLE.
- Cycle T1: `mem_rd` = 1, `mem_addr` = 0.
- Cycle T2: RAM returns the data.
- Cycle T3: `pix_valid` = 1, `x_pos` = 0, `y_pos` = 0, `frame_start` = 1.
- Read-to-output latency: 2 cycles, fixed.
- Line period: H_ACTIVE + H_BLANK cycles.
- Frame period: V_ACTIVE·(H_ACTIVE+H_BLANK) + V_BLANK = 34116 cycles at defaults.
- Output valid is contiguous for H_ACTIVE cycles per line.
- The two-stage output pipeline drains after leaving ACTIVE. The last pixel of a line appears 2 cycles after the last read.

## Configuration
- `FRAME_SCANNER_TEST_PATTERN_EN` defined:
  - `data_out` = 0x00 for x < H_ACTIVE/2, 0xFF otherwise. `mem_data` is ignored.
  - `mem_rd` is still driven, so timing is identical.
- Undefined: `data_out` = registered `mem_data`.

## Structure
- Shared package holds:
  - state enum (IDLE/ACTIVE/HBLANK/VBLANK);
  - `COORD_W` = 11;
  - `COORD_INVALID` = 11'h7FF.
- Sub-module `scan_counter`: column/row/address counters with terminal-count outputs, instantiated once. The FSM and output pipeline stay in `frame_scanner`.

## Test plan
- Reset: hold `rst` = 0 for 3 cycles. Expect `pix_valid` = 0, `x_pos`/`y_pos` = 7FF, `busy` = 0, `mem_rd` = 0.
- Single frame, RAM preloaded with addr[7:0], `frame_req` pulsed 1 cycle. Expect:
  - first valid beat 3 cycles later: (0,0), data 0x00, `frame_start` = 1;
  - beat (199,163) with data 32799[7:0] = 0x1F;
  - 32800 valid beats total;
  - `frame_done` at cycle 34116 after T0;
  - return to IDLE.
- Blanking: between the last pixel of one line and the first pixel of the next, 8 cycles with `pix_valid` = 0 and coords 7FF.
- `frame_req` held high: the second frame's `mem_addr` = 0 read occurs in the cycle after `frame_done`, with no IDLE cycle.
- Reset asserted at pixel (50,20): outputs return to reset values at the next edge, no `frame_done`. The following request starts again at address 0.
- With `FRAME_SCANNER_TEST_PATTERN_EN`: per frame, count of `data_out` = 0x00 equals 100·164 = 16400.
